// File: rtl/present_pkg.sv
// Shared PRESENT-80 decryption definitions: S-box tables, FSM state type,
// width constants and the forward/inverse key-schedule step functions.
package present_pkg;

    localparam int KEY_W  = 80;
    localparam int ROUNDS = 31;
    localparam int RC_W   = 5;

    localparam logic [RC_W-1:0] RC_LAST = RC_W'(ROUNDS);

    typedef enum logic [2:0] {
        IDLE,
        KEYEXP,
        WHITEN,
        ROUND,
        DONE
    } dec_state_t;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    // Forward key update: rotl 61, S-box on top nibble, xor round counter.
    function automatic logic [KEY_W-1:0] key_fwd(
        input logic [KEY_W-1:0] k,
        input logic [RC_W-1:0]  rc
    );
        logic [KEY_W-1:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = SBOX[t[79:76]];
        t[19:15]   = t[19:15] ^ rc;
        return t;
    endfunction

    // Exact inverse of key_fwd for the same rc value.
    function automatic logic [KEY_W-1:0] key_inv(
        input logic [KEY_W-1:0] k,
        input logic [RC_W-1:0]  rc
    );
        logic [KEY_W-1:0] t;
        t          = k;
        t[19:15]   = t[19:15] ^ rc;
        t[79:76]   = INV_SBOX[t[79:76]];
        return {t[60:0], t[79:61]};
    endfunction

endpackage

// File: rtl/PLayerDec.sv
// Inverse PRESENT bit permutation: permuted[i] = original[16*i mod 63],
// bit 63 fixed. Ports: Clock, original (64), permuted (64), done (flag).
module PLayerDec (
    input  logic        Clock,
    input  logic [63:0] original,
    output logic [63:0] permuted,
    output logic        done
);

    for (genvar i = 0; i < 63; i++) begin : g_perm
        assign permuted[i] = original[(16 * i) % 63];
    end
    assign permuted[63] = original[63];

    // The permutation is combinational; done only marks that a clock was seen.
    always_ff @(posedge Clock) begin
        done <= 1'b1;
    end

endmodule

// File: rtl/present_dec_ctrl_s_layer.sv
// Inverse S-box layer: 16 parallel INV_SBOX nibble lookups.
// Ports: din_i (64) in, dout_o (64) out; purely combinational.
module s_layer_dec
    import present_pkg::*;
(
    input  logic [63:0] din_i,
    output logic [63:0] dout_o
);

    for (genvar n = 0; n < 16; n++) begin : g_nib
        assign dout_o[4*n +: 4] = INV_SBOX[din_i[4*n +: 4]];
    end

endmodule

// File: rtl/present_dec_ctrl.sv
// Iterative PRESENT-80 decryption controller, one round per clock.
// Ports: Clock, Reset_n (sync, low), Start, Ciphertext, Key in;
//        Busy, Plaintext, Done (pulse), Round (debug rc) out.
module present_dec_ctrl
    import present_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [63:0]       Ciphertext,
    input  logic [KEY_W-1:0]  Key,
    output logic              Busy,
    output logic [63:0]       Plaintext,
    output logic              Done,
    output logic [RC_W-1:0]   Round
);

    dec_state_t        state_q;
    logic [63:0]       st_q;
    logic [KEY_W-1:0]  kr_q;
    logic [RC_W-1:0]   rc_q;
    logic [63:0]       pt_q;
    logic              busy_q;
    logic              done_q;

    logic [63:0]       st_perm;
    logic [63:0]       st_sub;
    logic [63:0]       st_d;
    logic [KEY_W-1:0]  kn;
    logic              pl_done_unused;

    PLayerDec u_player (
        .Clock    (Clock),
        .original (st_q),
        .permuted (st_perm),
        .done     (pl_done_unused)
    );

    s_layer_dec u_slayer (
        .din_i  (st_perm),
        .dout_o (st_sub)
    );

    // kn is the round key for this inverse round and the next kr.
    assign kn   = key_inv(kr_q, rc_q);
    assign st_d = st_sub ^ kn[79:16];

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            st_q    <= '0;
            kr_q    <= '0;
            rc_q    <= '0;
            pt_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (Start) begin
                        st_q    <= Ciphertext;
                        kr_q    <= Key;
                        rc_q    <= RC_W'(1);
                        busy_q  <= 1'b1;
                        state_q <= KEYEXP;
                    end
                end
                KEYEXP: begin
                    kr_q <= key_fwd(kr_q, rc_q);
                    if (rc_q == RC_LAST) begin
                        state_q <= WHITEN;
                    end else begin
                        rc_q <= rc_q + RC_W'(1);
                    end
                end
                WHITEN: begin
                    // kr now holds K32
                    st_q    <= st_q ^ kr_q[79:16];
                    state_q <= ROUND;
                end
                ROUND: begin
                    kr_q <= kn;
                    st_q <= st_d;
                    if (rc_q == RC_W'(1)) begin
                        pt_q    <= st_d;
                        rc_q    <= '0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        rc_q <= rc_q - RC_W'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Plaintext = pt_q;
    assign Done      = done_q;
    assign Round     = rc_q;

endmodule
